reg_file_32x32: RTL and testbench
=================================

# reg_file_32x32

Thirty-two-entry, two-read/one-write register file that consumes the one-hot load vector produced by the 5-to-32 write decoder. Each set load bit writes WriteData into the corresponding register on the rising clock edge. Register 0 is hardwired to zero. A sticky error flag records any load vector with more than one bit set; such a write is suppressed.

## Interface

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- BYPASS, 0, 1 = a read of the register being written this cycle returns WriteData; 0 = it returns the stored (old) value.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all registers and MultiHot_Err immediately.
- Load_In  input  32  one-hot write strobe from the 5-to-32 decoder; bit i selects register i; all-zero = no write.
- WriteData  input  WIDTH  data written to the selected register.
- ReadSelA  input  5  read address, port A.
- ReadSelB  input  5  read address, port B.
- ErrClear  input  1  synchronous clear of MultiHot_Err.
- ReadDataA  output  WIDTH  contents of register ReadSelA (combinational).
- ReadDataB  output  WIDTH  contents of register ReadSelB (combinational).
- MultiHot_Err  output  1  sticky flag: a load vector with two or more bits set has been seen.

## Operation

- Storage: registers R1..R31, WIDTH bits each. R0 is not stored; reads of address 0 always return 0.
- Write: on a rising Clk edge, if Load_In has exactly one bit i set and i != 0, then Ri <= WriteData. Load_In[0] alone means no write and no error.
- Zero load: Load_In == 0 means no write and no error.
- Multi-hot load: two or more bits set means no register changes, and MultiHot_Err <= 1 on that edge. Load_In[0] counts toward the popcount, so 32'h00000003 is an error.
- ErrClear: MultiHot_Err <= 0 on the edge. If a multi-hot load occurs on the same edge, set wins and the flag stays 1.
- Reads: ReadDataX = (ReadSelX == 0) ? 0 : R[ReadSelX]. Reads are purely combinational from the address and stored state.
- Bypass when BYPASS=1: if Load_In is a valid one-hot write to register k != 0 and ReadSelX == k, then ReadDataX = WriteData in the same cycle. Bypass never applies to address 0 or to a multi-hot load.
- Both read ports are independent and may address the same register.

## Timing

- Reset: asynchronous assert, with R1..R31 = 0 and MultiHot_Err = 0. ReadDataA and ReadDataB then read 0. Deassertion takes effect at the next Clk edge.
- Reset mid-write: Reset asserted coincident with a write edge leaves the register at 0. Reset dominates everything.
- Write latency: 1 cycle. The value is visible on the read ports the cycle after the write edge (BYPASS=0), or combinationally in the write cycle (BYPASS=1).
- Error latency: MultiHot_Err rises 1 edge after the offending Load_In is sampled. It holds until Reset or ErrClear.
- Read-during-write (BYPASS=0): a read returns the pre-edge value until the edge, then the new value.
- Back-to-back writes to the same register on consecutive edges: the last write wins and no cycles are lost.

## Test plan

- Reset then read all: assert Reset, then sweep ReadSelA/B over 0..31 -> every read returns 0 and MultiHot_Err = 0.
- Write/read sweep: for i = 1..31, write Load_In = 1<<i with WriteData = 32'hA5A50000+i, then read back on both ports -> each returns 32'hA5A50000+i; address 0 reads 0.
- Register 0 protection: write Load_In = 32'h00000001 with WriteData = 32'hFFFFFFFF -> ReadDataA(0) = 0 and MultiHot_Err = 0.
- Multi-hot: preload R3 = 32'h11111111 and R5 = 32'h22222222, then apply Load_In = 32'h00000028 with WriteData = 32'hDEADBEEF -> R3 and R5 are unchanged and MultiHot_Err = 1 after the edge. Apply ErrClear for one cycle -> flag = 0. Apply multi-hot and ErrClear on the same edge -> flag = 1.
- Read-during-write: R7 = 32'h1, then write 32'h2 to R7 with ReadSelA = 7 -> pre-edge ReadDataA = 32'h1 when BYPASS=0, or 32'h2 when BYPASS=1; post-edge = 32'h2 in both cases.
- Async reset mid-operation: write R9 = 32'hCAFEF00D, then assert Reset between clock edges -> ReadDataA(9) becomes 0 without a clock edge; the first write after deassertion succeeds.

Source files
------------

// File: rtl/reg_file_32x32.sv
// Thirty-two entry, two-read/one-write register file driven by a one-hot load vector.
// R0 reads as zero; multi-hot load vectors are dropped and latched into a sticky error flag.
module reg_file_32x32 #(
   parameter int WIDTH  = 32,
   parameter bit BYPASS = 1'b0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [31:0]      Load_In,
   input  logic [WIDTH-1:0] WriteData,
   input  logic [4:0]       ReadSelA,
   input  logic [4:0]       ReadSelB,
   input  logic             ErrClear,
   output logic [WIDTH-1:0] ReadDataA,
   output logic [WIDTH-1:0] ReadDataB,
   output logic             MultiHot_Err
);

   logic             w_multi_hot;
   logic [31:0]      w_we;
   logic [WIDTH-1:0] w_rd_view [0:31];
   logic [WIDTH-1:0] w_rd_a;
   logic [WIDTH-1:0] w_rd_b;

   logic [WIDTH-1:0] r_regs [1:31];
   logic             r_err;

   // Clearing the lowest set bit leaves something only when two or more bits were set.
   assign w_multi_hot = |(Load_In & (Load_In - 32'd1));
   assign w_we        = w_multi_hot ? 32'd0 : {Load_In[31:1], 1'b0};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 1; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (w_we[i]) begin
               r_regs[i] <= WriteData;
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_err <= 1'b0;
      end else if (w_multi_hot) begin
         r_err <= 1'b1;
      end else if (ErrClear) begin
         r_err <= 1'b0;
      end
   end

   always_comb begin
      w_rd_view[0] = '0;
      for (int i = 1; i < 32; i++) begin
         w_rd_view[i] = r_regs[i];
      end
   end

   // w_we[0] is always 0, so the forwarding path can never reach address 0.
   always_comb begin
      w_rd_a = w_rd_view[ReadSelA];
      w_rd_b = w_rd_view[ReadSelB];
      if (BYPASS && w_we[ReadSelA]) begin
         w_rd_a = WriteData;
      end
      if (BYPASS && w_we[ReadSelB]) begin
         w_rd_b = WriteData;
      end
   end

   assign ReadDataA    = w_rd_a;
   assign ReadDataB    = w_rd_b;
   assign MultiHot_Err = r_err;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed bench for reg_file_32x32: one instance without and one with write bypass share
// the stimulus; hand-computed expectations are queued and checked mid-cycle by a monitor.
module tb_reg_file_32x32;

   localparam int W  = 32;
   localparam int EW = 4 * W + 1;

   logic          clk;
   logic          rst;
   logic [31:0]   load_in;
   logic [W-1:0]  write_data;
   logic [4:0]    sel_a;
   logic [4:0]    sel_b;
   logic          err_clear;
   logic [W-1:0]  rd_a0, rd_b0, rd_a1, rd_b1;
   logic          err0, err1;

   logic [EW-1:0] exp_q[$];
   int            n_vec;
   int            n_err;

   reg_file_32x32 #(.WIDTH(W), .BYPASS(1'b0)) dut0 (
      .Clk(clk), .Reset(rst), .Load_In(load_in), .WriteData(write_data),
      .ReadSelA(sel_a), .ReadSelB(sel_b), .ErrClear(err_clear),
      .ReadDataA(rd_a0), .ReadDataB(rd_b0), .MultiHot_Err(err0)
   );

   reg_file_32x32 #(.WIDTH(W), .BYPASS(1'b1)) dut1 (
      .Clk(clk), .Reset(rst), .Load_In(load_in), .WriteData(write_data),
      .ReadSelA(sel_a), .ReadSelB(sel_b), .ErrClear(err_clear),
      .ReadDataA(rd_a1), .ReadDataB(rd_b1), .MultiHot_Err(err1)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic drive(input logic [31:0] load, input logic [W-1:0] wd,
                        input logic [4:0] sa, input logic [4:0] sb, input logic clr);
      @(posedge clk);
      #1;
      load_in    = load;
      write_data = wd;
      sel_a      = sa;
      sel_b      = sb;
      err_clear  = clr;
   endtask

   task automatic ex(input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1, input logic e);
      exp_q.push_back({a0, b0, a1, b1, e});
   endtask

   function automatic logic [W-1:0] v(input int i);
      return 32'hA5A50000 + i;
   endfunction

   // scoreboard
   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [EW-1:0] e;
         e = exp_q.pop_front();
         chk("rdA_nobyp", rd_a0, e[4*W:3*W+1]);
         chk("rdB_nobyp", rd_b0, e[3*W:2*W+1]);
         chk("rdA_byp",   rd_a1, e[2*W:W+1]);
         chk("rdB_byp",   rd_b1, e[W:1]);
         chk("err_nobyp", {31'd0, err0}, {31'd0, e[0]});
         chk("err_byp",   {31'd0, err1}, {31'd0, e[0]});
      end
   end

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b1;
      load_in    = '0;
      write_data = '0;
      sel_a      = '0;
      sel_b      = '0;
      err_clear  = 1'b0;

      // reset then read everything
      for (int i = 0; i < 32; i++) begin
         drive(32'd0, '0, 5'(i), 5'(31 - i), 1'b0);
         ex('0, '0, '0, '0, 1'b0);
      end
      drive(32'd0, '0, 5'd0, 5'd0, 1'b0);
      rst = 1'b0;
      ex('0, '0, '0, '0, 1'b0);

      // write / read sweep
      for (int i = 1; i < 32; i++) begin
         drive(32'd1 << i, v(i), 5'(i), 5'(i), 1'b0);
         ex('0, '0, v(i), v(i), 1'b0);
         drive(32'd0, '0, 5'(i), 5'(i), 1'b0);
         ex(v(i), v(i), v(i), v(i), 1'b0);
         drive(32'd0, '0, 5'd0, 5'(i), 1'b0);
         ex('0, v(i), '0, v(i), 1'b0);
      end
      for (int i = 1; i < 32; i++) begin
         drive(32'd0, '0, 5'(i), 5'(32 - i), 1'b0);
         ex(v(i), v(32 - i), v(i), v(32 - i), 1'b0);
      end

      // register 0 protection
      drive(32'h1, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
      ex('0, '0, '0, '0, 1'b0);
      drive(32'd0, '0, 5'd0, 5'd1, 1'b0);
      ex('0, v(1), '0, v(1), 1'b0);

      // multi-hot suppression and sticky flag
      drive(32'h8, 32'h11111111, 5'd3, 5'd5, 1'b0);
      ex(v(3), v(5), 32'h11111111, v(5), 1'b0);
      drive(32'h20, 32'h22222222, 5'd3, 5'd5, 1'b0);
      ex(32'h11111111, v(5), 32'h11111111, 32'h22222222, 1'b0);
      drive(32'h28, 32'hDEADBEEF, 5'd3, 5'd5, 1'b0);
      ex(32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b0);
      drive(32'd0, '0, 5'd3, 5'd5, 1'b0);
      ex(32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b1);
      drive(32'd0, '0, 5'd3, 5'd5, 1'b1);
      ex(32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b1);
      drive(32'd0, '0, 5'd3, 5'd5, 1'b0);
      ex(32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b0);
      drive(32'h28, 32'hDEADBEEF, 5'd3, 5'd5, 1'b1);
      ex(32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b0);
      drive(32'd0, '0, 5'd3, 5'd5, 1'b0);
      ex(32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b1);
      drive(32'h3, 32'hDEADBEEF, 5'd1, 5'd0, 1'b1);
      ex(v(1), '0, v(1), '0, 1'b1);
      drive(32'd0, '0, 5'd1, 5'd0, 1'b1);
      ex(v(1), '0, v(1), '0, 1'b1);
      drive(32'd0, '0, 5'd1, 5'd0, 1'b0);
      ex(v(1), '0, v(1), '0, 1'b0);

      // read during write, back-to-back writes
      drive(32'h80, 32'h1, 5'd7, 5'd7, 1'b0);
      ex(v(7), v(7), 32'h1, 32'h1, 1'b0);
      drive(32'h80, 32'h2, 5'd7, 5'd7, 1'b0);
      ex(32'h1, 32'h1, 32'h2, 32'h2, 1'b0);
      drive(32'd0, '0, 5'd7, 5'd7, 1'b0);
      ex(32'h2, 32'h2, 32'h2, 32'h2, 1'b0);

      // asynchronous reset between edges
      drive(32'h200, 32'hCAFEF00D, 5'd9, 5'd9, 1'b0);
      ex(v(9), v(9), 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
      drive(32'h6, '0, 5'd9, 5'd9, 1'b0);
      ex(32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
      drive(32'd0, '0, 5'd9, 5'd2, 1'b0);
      #1 rst = 1'b1;
      ex('0, '0, '0, '0, 1'b0);
      drive(32'd0, '0, 5'd9, 5'd9, 1'b0);
      ex('0, '0, '0, '0, 1'b0);
      drive(32'h200, 32'h12345678, 5'd9, 5'd2, 1'b0);
      rst = 1'b0;
      ex('0, '0, 32'h12345678, '0, 1'b0);
      drive(32'd0, '0, 5'd9, 5'd2, 1'b0);
      ex(32'h12345678, '0, 32'h12345678, '0, 1'b0);

      // drain: every queued expectation must have been consumed
      repeat (3) @(posedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
